md_unit: RTL

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the next pipelined MIPS core generation.
- Sits in the EX stage beside the ALU.
- Executes mult/multu/div/divu with configurable latency.
- Handles mthi/mtlo writes.
- Exposes a busy flag that the control unit uses to stall md-dependent instructions in D.

---
 rtl/md_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed combinationally from the operands at start and
// latched. A down-counter then models the configured latency before the
// latched result is committed to HI/LO.
//
//   state | meaning
//   IDLE  | waiting; accepts mult/multu/div/divu starts and mthi/mtlo writes
//   RUN   | operation in flight; busy=1, HI/LO hold, further starts ignored
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] ONES      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic             is_arith;
    logic             done;

    // mult/multu/div/divu occupy op codes 0..3
    assign is_arith = (op[2] == 1'b0);
    assign done     = (state == RUN) && (count == CNT_ONE);
    assign busy     = (state == RUN);

    // Result computed from the live operands; only sampled when a start is accepted.
    // Divide-by-zero and the signed overflow case are resolved explicitly so the
    // divider never sees an undefined quotient.
    always_comb begin
        prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        calc_hi = '0;
        calc_lo = '0;
        case (op)
            3'd0: {calc_hi, calc_lo} = prod_s;
            3'd1: {calc_hi, calc_lo} = prod_u;
            3'd2: begin
                if (b == '0) begin
                    calc_hi = a;
                    calc_lo = ONES;
                end else if ((a == MOST_NEG) && (b == ONES)) begin
                    calc_hi = '0;
                    calc_lo = a;
                end else begin
                    calc_lo = $signed(a) / $signed(b);
                    calc_hi = $signed(a) % $signed(b);
                end
            end
            3'd3: begin
                if (b == '0) begin
                    calc_hi = a;
                    calc_lo = ONES;
                end else begin
                    calc_lo = a / b;
                    calc_hi = a % b;
                end
            end
            default: ;
        endcase
    end

    // Sequencing FSM with latency down-counter and latched result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_arith) begin
                        res_hi <= calc_hi;
                        res_lo <= calc_lo;
                        count  <= op[1] ? DIV_LOAD : MULT_LOAD;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (count == CNT_ONE) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // HI/LO update: commit at completion, or direct mthi/mtlo writes while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if ((state == IDLE) && start) begin
            if (op == 3'd4) hi <= a;
            if (op == 3'd5) lo <= a;
        end
    end

endmodule
